wb_rr_intercon: RTL

WB_RR_INTERCON -- requirements
Module: wb_rr_intercon

---
 rtl/wb_rr_intercon_if.sv | 48 ++++
 rtl/wb_rr_intercon.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_intercon_if.sv
// Bus bundle for wb_rr_intercon.
//   m_*_i / m_*_o : packed per-master Wishbone signals, master k at slice k
//   s_*_o / s_*_i : shared slave request bus plus per-slave cyc/stb/ack/err/data
// Modports:
//   slave  - the interconnect's view (it is the slave of the masters)
//   master - the environment's view (masters and slaves around the interconnect)
interface wb_rr_intercon_if #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SW = DW / 8;

  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*SW-1:0] m_sel_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M-1:0]    m_cyc_i;
  logic [NUM_M-1:0]    m_stb_i;
  logic [NUM_M*DW-1:0] m_dat_o;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;

  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic                s_we_o;
  logic [NUM_S-1:0]    s_cyc_o;
  logic [NUM_S-1:0]    s_stb_o;
  logic [NUM_S*DW-1:0] s_dat_i;
  logic [NUM_S-1:0]    s_ack_i;
  logic [NUM_S-1:0]    s_err_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_rr_intercon.sv
// Round-robin Wishbone interconnect: NUM_M masters share one slave bus,
// slave selected by the top 4 address bits of the granted master.
// Ports:
//   clk_i  - system clock, all state on rising edge
//   rst_i  - synchronous active-low reset
//   bus    - wb_rr_intercon_if.slave bundle (master and slave side signals)
//   gnt_o  - registered one-hot grant, all-zero when idle
//
// state | meaning
// IDLE  | no grant; arbitrate among m_cyc_i from rr_ptr upward
// BUSY  | grant held while granted master keeps cyc high
// TOERR | one-cycle forced error after TIMEOUT cycles without ack/err
module wb_rr_intercon #(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_rr_intercon_if.slave  bus,
  output logic [NUM_M-1:0] gnt_o
);
  localparam int SW = DW / 8;
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, TOERR} state_t;

  state_t           state_q;
  logic [NUM_M-1:0] gnt_q;
  logic [MW-1:0]    gidx_q;
  logic [MW-1:0]    rr_ptr_q;
  logic [15:0]      cnt_q;

  logic          g_cyc, g_stb, g_we;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;
  logic [3:0]    slv_idx;
  logic          mapped, sl_ack, sl_err;
  logic [DW-1:0] sl_dat;
  logic          arb_hit;
  logic [MW-1:0] arb_idx;

  assign gnt_o = gnt_q;

  // Granted master's request signals
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (gidx_q == MW'(m)) begin
        g_cyc = bus.m_cyc_i[m];
        g_stb = bus.m_stb_i[m];
        g_we  = bus.m_we_i[m];
        g_adr = bus.m_adr_i[m*AW +: AW];
        g_dat = bus.m_dat_i[m*DW +: DW];
        g_sel = bus.m_sel_i[m*SW +: SW];
      end
    end
  end

  assign slv_idx = g_adr[AW-1 -: 4];

  // Slave decode; an index with no matching slave leaves mapped low
  always_comb begin
    mapped = 1'b0;
    sl_ack = 1'b0;
    sl_err = 1'b0;
    sl_dat = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (slv_idx == 4'(s)) begin
        mapped = 1'b1;
        sl_ack = bus.s_ack_i[s];
        sl_err = bus.s_err_i[s];
        sl_dat = bus.s_dat_i[s*DW +: DW];
      end
    end
  end

  // First requester at or after rr_ptr, with wrap
  always_comb begin
    int j;
    j       = 0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      j = (int'(rr_ptr_q) + i) % NUM_M;
      if (!arb_hit && bus.m_cyc_i[j]) begin
        arb_hit = 1'b1;
        arb_idx = MW'(j);
      end
    end
  end

  // Outputs are forced quiet while rst_i is low so an aborted access never
  // sees an ack/err in the reset cycle itself.
  always_comb begin
    logic busy, toerr, req, g_ack, g_err;
    busy  = rst_i && (state_q == BUSY);
    toerr = rst_i && (state_q == TOERR);
    req   = g_cyc & g_stb;
    g_ack = busy & req & sl_ack & ~sl_err;
    g_err = (busy & req & (sl_err | ~mapped)) | toerr;

    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;

    if (rst_i && (state_q != IDLE)) begin
      bus.s_adr_o = g_adr;
      bus.s_dat_o = g_dat;
      bus.s_sel_o = g_sel;
      bus.s_we_o  = g_we;
    end
    for (int s = 0; s < NUM_S; s++) begin
      if (busy && slv_idx == 4'(s)) begin
        bus.s_cyc_o[s] = g_cyc;
        bus.s_stb_o[s] = req;
      end
    end
    for (int m = 0; m < NUM_M; m++) begin
      if (gidx_q == MW'(m)) begin
        bus.m_ack_o[m]          = g_ack;
        bus.m_err_o[m]          = g_err;
        bus.m_dat_o[m*DW +: DW] = (busy && mapped) ? sl_dat : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (arb_hit) begin
            state_q          <= BUSY;
            gnt_q            <= '0;
            gnt_q[arb_idx]   <= 1'b1;
            gidx_q           <= arb_idx;
            rr_ptr_q         <= (arb_idx == MW'(NUM_M - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
          end else if (!g_stb || sl_ack || sl_err || !mapped) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            // An ack in the matching cycle takes the branch above, so ack wins.
            if (cnt_q + 16'd1 == 16'(TIMEOUT)) state_q <= TOERR;
          end
        end
        TOERR: begin
          cnt_q <= '0;
          if (g_cyc) begin
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end
endmodule
